// File: rtl/rsa_operand_loader_pkg.sv
// Shared definitions for the RSA operand loader.
//   KEY_W_DEF / BYTE_W_DEF : default operand and beat widths
//   num_beats()            : beats needed to fill one operand
//   state_e                : loader FSM encoding (7 states, 3 bits)
package rsa_operand_loader_pkg;

  localparam int unsigned KEY_W_DEF  = 1024;
  localparam int unsigned BYTE_W_DEF = 8;

  function automatic int unsigned num_beats(input int unsigned key_w, input int unsigned byte_w);
    return key_w / byte_w;
  endfunction

  typedef enum logic [2:0] {
    StData     = 3'd0,
    StExp      = 3'd1,
    StMod      = 3'd2,
    StCheck    = 3'd3,
    StLaunch   = 3'd4,
    StWaitAck  = 3'd5,
    StWaitDone = 3'd6
  } state_e;

endpackage

// File: rtl/rsa_operand_loader_if.sv
// Host byte-stream handshake (valid/ready) into the RSA operand loader.
//   in_valid : host byte valid
//   in_data  : host byte
//   in_ready : loader accepts the byte this cycle
// master = host side, slave = loader side.
interface rsa_operand_loader_if
  import rsa_operand_loader_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEF
);

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/rsa_operand_loader_shift_in.sv
// Operand assembler: KEY_W-bit shift register fed BYTE_W bits per enabled beat, MSB byte first,
// plus a beat counter that wraps after the final beat of the operand.
//   i_clk   : clock
//   i_reset : synchronous active-high reset (clears register and counter)
//   i_en    : shift in i_din this cycle
//   i_din   : incoming beat
//   o_q     : assembled operand
//   o_last  : this enabled beat completes the operand
module rsa_operand_loader_shift_in
  import rsa_operand_loader_pkg::*;
#(
  parameter int unsigned KEY_W  = KEY_W_DEF,
  parameter int unsigned BYTE_W = BYTE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_din,
  output logic [KEY_W-1:0]  o_q,
  output logic              o_last
);

  localparam int unsigned NB   = num_beats(KEY_W, BYTE_W);
  localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NB - 1);

  logic [KEY_W-1:0] r_q;
  logic [CntW-1:0]  r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LastBeat);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_q   <= {r_q[KEY_W-BYTE_W-1:0], i_din};
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_q    = r_q;
  assign o_last = i_en & w_at_last;

endmodule

// File: rtl/rsa_operand_loader.sv
// Upstream feeder for the RSA modular-exponentiation core. Collects message, exponent and
// modulus from a host byte stream, rejects an even/zero modulus, pulses the core's active-low
// start and follows the core's ready line until the result is valid.
//   i_clk, i_reset : clock, synchronous active-high reset
//   io_host        : host byte stream (valid/ready), slave side
//   o_op_data      : assembled message  -> core indata
//   o_op_exp       : assembled exponent -> core inExp
//   o_op_mod       : assembled modulus  -> core inMod
//   o_ds_n         : core start strobe, active-low, one cycle per launch
//   i_cy_ready     : core ready (high = idle / result valid)
//   o_busy         : operation in progress
//   o_op_done      : one-cycle pulse, core result valid
//   o_err          : sticky bad-modulus flag, cleared by the next accepted byte
module rsa_operand_loader
  import rsa_operand_loader_pkg::*;
#(
  parameter int unsigned KEY_W  = KEY_W_DEF,
  parameter int unsigned BYTE_W = BYTE_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  rsa_operand_loader_if.slave         io_host,
  output logic [KEY_W-1:0]            o_op_data,
  output logic [KEY_W-1:0]            o_op_exp,
  output logic [KEY_W-1:0]            o_op_mod,
  output logic                        o_ds_n,
  input  logic                        i_cy_ready,
  output logic                        o_busy,
  output logic                        o_op_done,
  output logic                        o_err
);

  state_e r_state, w_state_d;
  logic   r_busy, r_err, r_op_done;

  logic w_ready, w_xfer;
  logic w_en_data, w_en_exp, w_en_mod;
  logic w_last_data, w_last_exp, w_last_mod;
  logic w_launch, w_done, w_fail, w_mod_bad;
  logic [KEY_W-1:0] w_mod;

  assign w_xfer    = io_host.in_valid & w_ready;
  assign w_en_data = w_xfer & (r_state == StData);
  assign w_en_exp  = w_xfer & (r_state == StExp);
  assign w_en_mod  = w_xfer & (r_state == StMod);

  rsa_operand_loader_shift_in #(.KEY_W(KEY_W), .BYTE_W(BYTE_W)) u_shift_data (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_en_data),
    .i_din   (io_host.in_data),
    .o_q     (o_op_data),
    .o_last  (w_last_data)
  );

  rsa_operand_loader_shift_in #(.KEY_W(KEY_W), .BYTE_W(BYTE_W)) u_shift_exp (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_en_exp),
    .i_din   (io_host.in_data),
    .o_q     (o_op_exp),
    .o_last  (w_last_exp)
  );

  rsa_operand_loader_shift_in #(.KEY_W(KEY_W), .BYTE_W(BYTE_W)) u_shift_mod (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_en_mod),
    .i_din   (io_host.in_data),
    .o_q     (w_mod),
    .o_last  (w_last_mod)
  );

  assign o_op_mod = w_mod;

  // Zero is already even; the explicit compare keeps the intent readable.
  assign w_mod_bad = ~w_mod[0] | (w_mod == '0);

  always_comb begin
    w_state_d = r_state;
    w_ready   = 1'b0;
    w_launch  = 1'b0;
    w_done    = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      StData: begin
        w_ready = 1'b1;
        if (w_last_data) w_state_d = StExp;
      end
      StExp: begin
        w_ready = 1'b1;
        if (w_last_exp) w_state_d = StMod;
      end
      StMod: begin
        w_ready = 1'b1;
        if (w_last_mod) w_state_d = StCheck;
      end
      StCheck: begin
        if (w_mod_bad) begin
          w_fail    = 1'b1;
          w_state_d = StData;
        end else begin
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        // Stall here while the core is still busy with an earlier job.
        if (i_cy_ready) begin
          w_launch  = 1'b1;
          w_state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (!i_cy_ready) w_state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_cy_ready) begin
          w_done    = 1'b1;
          w_state_d = StData;
        end
      end
      default: w_state_d = StData;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StData;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_op_done <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_op_done <= w_done;
      if (w_en_data) begin
        r_busy <= 1'b1;
        r_err  <= 1'b0;
      end else if (w_fail) begin
        r_busy <= 1'b0;
        r_err  <= 1'b1;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign io_host.in_ready = w_ready;
  // Start strobe is decoded from the state register; reset masks it in the cycle it is sampled.
  assign o_ds_n    = ~(w_launch & ~i_reset);
  assign o_busy    = r_busy;
  assign o_op_done = r_op_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_rsa_operand_loader.sv
module tb_rsa_operand_loader;

  localparam int KeyW    = 32;
  localparam int ByteW   = 8;
  localparam int CoreLat = 3;

  typedef struct {
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] m;
    bit          bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_data, op_exp, op_mod;
  logic        ds_n, cy_ready, busy, op_done, err;

  rsa_operand_loader_if #(.BYTE_W(ByteW)) host_if ();

  rsa_operand_loader #(.KEY_W(KeyW), .BYTE_W(ByteW)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .io_host    (host_if),
    .o_op_data  (op_data),
    .o_op_exp   (op_exp),
    .o_op_mod   (op_mod),
    .o_ds_n     (ds_n),
    .i_cy_ready (cy_ready),
    .o_busy     (busy),
    .o_op_done  (op_done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_pulses = 0;
  int ds_pulses = 0;
  int dbl_low = 0;
  int overlap = 0;
  int outstanding = 0;
  int ready_viol = 0;
  int core_cnt = 0;
  bit core_hold = 1'b0;
  bit prev_low = 1'b0;
  bit in_window = 1'b0;

  // Behavioural core: drops ready for CoreLat cycles after each start strobe.
  assign cy_ready = (core_cnt == 0) && !core_hold;

  always @(posedge clk) begin
    if (ds_n === 1'b0) core_cnt <= CoreLat;
    else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    if (reset) begin
      outstanding = 0;
    end else begin
      if (op_done === 1'b1 && outstanding > 0) outstanding--;
      if (ds_n === 1'b0) begin
        ds_pulses++;
        outstanding++;
        if (outstanding > 1) overlap++;
        if (prev_low) dbl_low++;
      end
    end
    prev_low = (ds_n === 1'b0);
    if (in_window && host_if.in_ready) ready_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(host_if.in_ready), 1);
    chk("rst_ds_n", 32'(ds_n), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_done", 32'(op_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_op_data", op_data, 0);
    chk("rst_op_exp", op_exp, 0);
    chk("rst_op_mod", op_mod, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_window = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        host_if.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    host_if.in_valid = 1'b1;
    host_if.in_data  = b;
    n = 0;
    while (host_if.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles want 1", n);
    end
    @(negedge clk);
    host_if.in_valid = 1'b0;
  endtask

  // Sends all 12 bytes; returns in the check cycle (cycle after the last transfer).
  task automatic load_ops(input vec_t v, input bit rnd);
    logic [95:0] s;
    s = {v.d, v.e, v.m};
    for (int i = 0; i < 12; i++) begin
      send_byte(s[95-8*i -: 8], rnd);
      if (i == 0) begin
        chk("busy_after_first", 32'(busy), 1);
        chk("err_clr_first", 32'(err), 0);
      end
    end
    in_window = 1'b1;
    chk("check_in_ready", 32'(host_if.in_ready), 0);
    chk("check_ds_n", 32'(ds_n), 1);
  endtask

  // Called in the launch cycle with the core ready.
  task automatic expect_launch(input vec_t v);
    int n;
    chk("launch_ds_n", 32'(ds_n), 0);
    exp_pulses++;
    chk("launch_op_data", op_data, v.d);
    chk("launch_op_exp", op_exp, v.e);
    chk("launch_op_mod", op_mod, v.m);
    chk("launch_busy", 32'(busy), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (op_done !== 1'b1 && n < 50);
    in_window = 1'b0;
    chk("op_done_seen", 32'(op_done), 1);
    chk("op_done_latency", n, CoreLat + 2);
    chk("done_busy", 32'(busy), 0);
    chk("done_in_ready", 32'(host_if.in_ready), 1);
    chk("done_op_data_held", op_data, v.d);
    chk("done_op_mod_held", op_mod, v.m);
    @(negedge clk);
    chk("op_done_width", 32'(op_done), 0);
  endtask

  vec_t vecs [6];
  vec_t v;
  int   p0, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h12345678, 32'h00000003, 32'h0000000D, 1'b0};
    vecs[1] = '{32'h12345678, 32'h00000003, 32'h0000000C, 1'b1};
    vecs[2] = '{32'h12345678, 32'h00000003, 32'h00000000, 1'b1};
    vecs[3] = '{32'hAABBCCDD, 32'h00010001, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 32'h80000001, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'h12345678, 32'h00000002, 1'b1};

    reset = 1'b1;
    host_if.in_valid = 1'b0;
    host_if.in_data  = '0;
    @(negedge clk);
    chk("ds_n_in_reset", 32'(ds_n), 1);
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals();

    // Table: continuous streaming, good and bad moduli.
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      load_ops(v, 1'b0);
      @(negedge clk);
      if (v.bad) begin
        in_window = 1'b0;
        chk("bad_err", 32'(err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_in_ready", 32'(host_if.in_ready), 1);
        chk("bad_ds_n", 32'(ds_n), 1);
        @(negedge clk);
        chk("err_sticky", 32'(err), 1);
      end else begin
        expect_launch(v);
      end
    end

    // Core busy at launch: start held off until ready returns.
    core_hold = 1'b1;
    load_ops(vecs[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ds_n", 32'(ds_n), 1);
      chk("stall_in_ready", 32'(host_if.in_ready), 0);
    end
    core_hold = 1'b0;
    #1;
    expect_launch(vecs[0]);

    // Gappy host valid.
    for (int r = 0; r < 2; r++) begin
      load_ops(vecs[0], 1'b1);
      @(negedge clk);
      expect_launch(vecs[0]);
    end

    // Reset in the exponent phase after two beats.
    for (int i = 0; i < 6; i++) send_byte(vecs[3].d[31-8*(i%4) -: 8], 1'b0);
    chk("pre_rst_busy", 32'(busy), 1);
    do_reset();

    // Reset while waiting for the core result.
    load_ops(vecs[3], 1'b0);
    @(negedge clk);
    chk("wd_launch_ds_n", 32'(ds_n), 0);
    exp_pulses++;
    @(negedge clk);
    @(negedge clk);
    chk("wd_busy", 32'(busy), 1);
    do_reset();

    // Reset sampled in the launch cycle masks the strobe.
    load_ops(vecs[0], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("launch_rst_ds_n", 32'(ds_n), 1);
    @(negedge clk);
    reset = 1'b0;
    in_window = 1'b0;
    check_reset_vals();

    // Normal operation after resets.
    load_ops(vecs[0], 1'b0);
    @(negedge clk);
    expect_launch(vecs[0]);

    // Back-to-back: second stream queued behind the first.
    p0 = ds_pulses;
    d0 = outstanding;
    load_ops(vecs[3], 1'b0);
    in_window = 1'b0;
    exp_pulses++;
    load_ops(vecs[4], 1'b0);
    @(negedge clk);
    expect_launch(vecs[4]);
    chk("b2b_pulses", ds_pulses - p0, 2);
    chk("b2b_outstanding", outstanding - d0, 0);

    chk("ds_n_pulse_count", ds_pulses, exp_pulses);
    chk("ds_n_double_low", dbl_low, 0);
    chk("launch_overlap", overlap, 0);
    chk("in_ready_window", ready_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
